// File: rtl/ddr2_port_arb.sv
// Arbiter for the shared DDR2 MIG user port: serialises read and write client
// transfers, yields to auto-refresh, counts beats and aborts stalled transfers.
module ddr2_port_arb #(
  parameter int unsigned RD_PRIORITY = 0,
  parameter int unsigned WDOG_CYCLES = 4096,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned LEN_W       = 10
) (
  input  logic              clk0,
  input  logic              rst0,
  input  logic              mig_init_done,
  input  logic              mig_auto_ref_req,
  input  logic              mig_ar_done,
  input  logic              rd_mem_req,
  input  logic [ADDR_W-1:0] rd_mem_addr,
  input  logic [LEN_W-1:0]  rd_xfr_len,
  input  logic              rd_beat,
  output logic              rd_mem_grant,
  input  logic              wr_mem_req,
  input  logic [ADDR_W-1:0] wr_mem_addr,
  input  logic [LEN_W-1:0]  wr_xfr_len,
  input  logic              wr_beat,
  output logic              wr_mem_grant,
  output logic              eng_start,
  output logic              eng_is_read,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [LEN_W-1:0]  eng_len,
  output logic              eng_abort,
  output logic              arb_busy,
  output logic              err_timeout
);

  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_XFER    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_REFRESH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              last_rd_q, last_rd_d;
  logic              ref_pend_q, ref_pend_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              pick_rd;
  logic              act_beat;
  logic              wdog_fire;

  // Read wins a tie when prioritised or when the write side was served last.
  assign pick_rd  = rd_mem_req && (!wr_mem_req || (RD_PRIORITY != 0) || !last_rd_q);
  assign act_beat = is_read_q ? rd_beat : wr_beat;

  always_comb begin
    // NOTE: every signal assigned below gets its hold value first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    last_rd_d  = last_rd_q;
    ref_pend_d = ref_pend_q;
    is_read_d  = is_read_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    wdog_fire  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mig_init_done) begin
          if (mig_auto_ref_req || ref_pend_q) begin
            state_d    = S_REFRESH;
            ref_pend_d = 1'b0;
          end else if (rd_mem_req || wr_mem_req) begin
            state_d   = S_GRANT;
            is_read_d = pick_rd;
            addr_d    = pick_rd ? rd_mem_addr : wr_mem_addr;
            len_d     = pick_rd ? rd_xfr_len : wr_xfr_len;
          end
        end
      end
      S_GRANT: begin
        last_rd_d = is_read_q;
        cnt_d     = len_q;
        wdog_d    = '0;
        state_d   = (len_q == '0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (mig_auto_ref_req) ref_pend_d = 1'b1;
        if (act_beat) begin
          wdog_d = '0;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = S_DONE;
        end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          // This is the last permitted beat-less cycle: abort right here.
          wdog_fire = 1'b1;
          err_d     = 1'b1;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_REFRESH: if (mig_ar_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q    <= S_IDLE;
      last_rd_q  <= 1'b0;
      ref_pend_q <= 1'b0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_rd_q  <= last_rd_d;
      ref_pend_q <= ref_pend_d;
      is_read_q  <= is_read_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
    end
  end

  assign rd_mem_grant = (state_q == S_GRANT) && is_read_q;
  assign wr_mem_grant = (state_q == S_GRANT) && !is_read_q;
  assign eng_start    = (state_q == S_GRANT) && (len_q != '0);
  assign eng_is_read  = is_read_q;
  assign eng_addr     = addr_q;
  assign eng_len      = len_q;
  assign eng_abort    = wdog_fire;
  assign arb_busy     = (state_q != S_IDLE);
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_ddr2_port_arb.sv
// Bench for ddr2_port_arb: round-robin (inst 0) and read-priority (inst 1)
// copies checked every cycle against a transaction-level model.
module tb_ddr2_port_arb;

  localparam int AW = 25;
  localparam int LW = 10;
  localparam int WD = 16;

  logic clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  logic rst0, init_done, aref, ar_done, rd_beat, wr_beat;
  logic          rd_req [2];
  logic          wr_req [2];
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] wr_addr [2];
  logic [LW-1:0] rd_len [2];
  logic [LW-1:0] wr_len [2];
  logic          rd_gnt [2];
  logic          wr_gnt [2];
  logic          start [2];
  logic          is_rd [2];
  logic          abort [2];
  logic          busy [2];
  logic          err [2];
  logic [AW-1:0] e_addr [2];
  logic [LW-1:0] e_len [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    ddr2_port_arb #(
      .RD_PRIORITY(k), .WDOG_CYCLES(WD), .ADDR_W(AW), .LEN_W(LW)
    ) u_dut (
      .clk0(clk0), .rst0(rst0),
      .mig_init_done(init_done), .mig_auto_ref_req(aref), .mig_ar_done(ar_done),
      .rd_mem_req(rd_req[k]), .rd_mem_addr(rd_addr[k]), .rd_xfr_len(rd_len[k]),
      .rd_beat(rd_beat), .rd_mem_grant(rd_gnt[k]),
      .wr_mem_req(wr_req[k]), .wr_mem_addr(wr_addr[k]), .wr_xfr_len(wr_len[k]),
      .wr_beat(wr_beat), .wr_mem_grant(wr_gnt[k]),
      .eng_start(start[k]), .eng_is_read(is_rd[k]), .eng_addr(e_addr[k]),
      .eng_len(e_len[k]), .eng_abort(abort[k]), .arb_busy(busy[k]),
      .err_timeout(err[k])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_GRANTED, P_MOVING, P_WRAPUP, P_REFRESH} phase_e;
  typedef struct {
    phase_e        ph;
    bit            last_rd;
    bit            pend;
    bit            dir;
    bit            err;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    int            left;
    int            stall;
  } mstate_t;

  mstate_t m [2];
  bit glog [2][$];

  function automatic mstate_t m_reset();
    mstate_t s;
    s.ph = P_IDLE; s.last_rd = 1'b0; s.pend = 1'b0; s.dir = 1'b0; s.err = 1'b0;
    s.addr = '0; s.len = '0; s.left = 0; s.stall = 0;
    return s;
  endfunction

  function automatic bit m_beat(input int k);
    return m[k].dir ? rd_beat : wr_beat;
  endfunction

  function automatic void m_step(input int k);
    bit take_rd;
    case (m[k].ph)
      P_IDLE: if (init_done) begin
        if (aref || m[k].pend) begin
          m[k].ph = P_REFRESH;
          m[k].pend = 1'b0;
        end else if (rd_req[k] || wr_req[k]) begin
          if (rd_req[k] && wr_req[k]) take_rd = (k == 1) ? 1'b1 : !m[k].last_rd;
          else take_rd = rd_req[k];
          m[k].dir  = take_rd;
          m[k].addr = take_rd ? rd_addr[k] : wr_addr[k];
          m[k].len  = take_rd ? rd_len[k] : wr_len[k];
          m[k].ph   = P_GRANTED;
        end
      end
      P_GRANTED: begin
        m[k].last_rd = m[k].dir;
        m[k].left = int'(m[k].len);
        m[k].stall = 0;
        m[k].ph = (m[k].left == 0) ? P_WRAPUP : P_MOVING;
      end
      P_MOVING: begin
        if (aref) m[k].pend = 1'b1;
        if (m_beat(k)) begin
          m[k].left--;
          m[k].stall = 0;
          if (m[k].left == 0) m[k].ph = P_WRAPUP;
        end else begin
          m[k].stall++;
          if (m[k].stall == WD) begin
            m[k].err = 1'b1;
            m[k].ph = P_WRAPUP;
          end
        end
      end
      P_WRAPUP:  m[k].ph = P_IDLE;
      P_REFRESH: if (ar_done) m[k].ph = P_IDLE;
      default:   m[k].ph = P_IDLE;
    endcase
  endfunction

  // Compare process: outputs are sampled mid-cycle, then the model advances.
  always @(negedge clk0) begin
    for (int k = 0; k < 2; k++) begin
      if (rst0) m[k] = m_reset();
      check($sformatf("i%0d rd_grant", k), rd_gnt[k], m[k].ph == P_GRANTED && m[k].dir);
      check($sformatf("i%0d wr_grant", k), wr_gnt[k], m[k].ph == P_GRANTED && !m[k].dir);
      check($sformatf("i%0d eng_start", k), start[k], m[k].ph == P_GRANTED && m[k].len != 0);
      check($sformatf("i%0d eng_is_read", k), is_rd[k], m[k].dir);
      check($sformatf("i%0d eng_addr", k), e_addr[k], m[k].addr);
      check($sformatf("i%0d eng_len", k), e_len[k], m[k].len);
      check($sformatf("i%0d eng_abort", k), abort[k],
            m[k].ph == P_MOVING && !m_beat(k) && (m[k].stall + 1 == WD));
      check($sformatf("i%0d arb_busy", k), busy[k], m[k].ph != P_IDLE);
      check($sformatf("i%0d err_timeout", k), err[k], m[k].err);
      if (rd_gnt[k] || wr_gnt[k]) glog[k].push_back(rd_gnt[k]);
      if (!rst0) m_step(k);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  task automatic set_rd(input bit req, input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int k = 0; k < 2; k++) begin
      rd_req[k] = req; rd_addr[k] = a; rd_len[k] = l;
    end
  endtask

  task automatic set_wr(input bit req, input logic [AW-1:0] a, input logic [LW-1:0] l);
    for (int k = 0; k < 2; k++) begin
      wr_req[k] = req; wr_addr[k] = a; wr_len[k] = l;
    end
  endtask

  task automatic drop_reqs();
    for (int k = 0; k < 2; k++) begin
      rd_req[k] = 1'b0; wr_req[k] = 1'b0;
    end
  endtask

  task automatic wait_gnt(input int budget, output bit got_rd);
    int n = 0;
    while (!(rd_gnt[0] || wr_gnt[0]) && n < budget) begin
      tick();
      n++;
    end
    check("grant_within_budget", n < budget, 1);
    got_rd = rd_gnt[0];
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    rst0 = 1'b1;
    tick(2);
    rst0 = 1'b0;
  endtask

  function automatic logic [3:0] pack4(input int k);
    logic [3:0] v = '0;
    for (int i = 0; i < 4 && i < glog[k].size(); i++) v = {v[2:0], glog[k][i]};
    return v;
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    bit got_rd;
    int n;
    int thr;

    rst0 = 1'b1; init_done = 1'b0; aref = 1'b0; ar_done = 1'b0;
    rd_beat = 1'b0; wr_beat = 1'b0;
    set_rd(0, '0, '0); set_wr(0, '0, '0);
    tick(3);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_busy_i%0d", k), busy[k], 0);
      check($sformatf("reset_grant_i%0d", k), rd_gnt[k] | wr_gnt[k], 0);
      check($sformatf("reset_err_i%0d", k), err[k], 0);
      check($sformatf("reset_addr_i%0d", k), e_addr[k], 0);
    end
    rst0 = 1'b0;

    // Init gating, then an 8-beat read.
    set_rd(1, 25'h000100, 10'd8);
    tick(50);
    check("no_grant_before_init", glog[0].size(), 0);
    init_done = 1'b1;
    tick();
    check("init_rd_grant", rd_gnt[0], 1);
    check("init_eng_start", start[0], 1);
    check("init_is_read", is_rd[0], 1);
    check("init_addr", e_addr[0], 25'h000100);
    check("init_len", e_len[0], 8);
    drop_reqs();
    rd_beat = 1'b1;
    tick(9);
    check("init_done_state_busy", busy[0], 1);
    rd_beat = 1'b0;
    tick();
    check("init_back_idle", busy[0], 0);

    // Contention from reset: round-robin alternates, priority keeps reading.
    do_reset();
    glog[0].delete(); glog[1].delete();
    set_rd(1, 25'h000200, 10'd4); set_wr(1, 25'h000300, 10'd4);
    rd_beat = 1'b1; wr_beat = 1'b1;
    n = 0;
    while (glog[0].size() < 4 && n < 200) begin
      tick();
      n++;
    end
    check("contention_within_budget", n < 200, 1);
    drop_reqs();
    wait_idle(50);
    rd_beat = 1'b0; wr_beat = 1'b0;
    check("rr_grant_count", glog[0].size(), 4);
    check("rr_order_RWRW", pack4(0), 4'b1010);
    check("prio_grant_count", glog[1].size(), 4);
    check("prio_order_RRRR", pack4(1), 4'b1111);

    // Refresh requested mid-write; pending read waits for mig_ar_done.
    set_wr(1, 25'h000400, 10'd16);
    wr_beat = 1'b1;
    wait_gnt(20, got_rd);
    check("refresh_wr_granted", got_rd, 0);
    drop_reqs();
    tick(5);
    aref = 1'b1;
    set_rd(1, 25'h000500, 10'd2);
    glog[0].delete(); glog[1].delete();
    tick(20);
    wr_beat = 1'b0;
    check("refresh_state_busy", busy[0], 1);
    check("refresh_no_grant", glog[0].size(), 0);
    aref = 1'b0; ar_done = 1'b1;
    tick();
    ar_done = 1'b0;
    check("after_refresh_idle", busy[0], 0);
    check("after_refresh_no_grant_yet", rd_gnt[0], 0);
    tick();
    check("pending_rd_granted", rd_gnt[0], 1);
    check("pending_rd_addr", e_addr[0], 25'h000500);
    drop_reqs();
    rd_beat = 1'b1;
    wait_idle(40);
    rd_beat = 1'b0;

    // Zero-length write: grant without start, idle two cycles later.
    set_wr(1, 25'h000600, 10'd0);
    wait_gnt(20, got_rd);
    check("zero_len_wr_grant", wr_gnt[0], 1);
    check("zero_len_no_start", start[0], 0);
    drop_reqs();
    tick();
    check("zero_len_done_busy", busy[0], 1);
    tick();
    check("zero_len_idle", busy[0], 0);

    // Watchdog: 2 of 4 beats, abort on the 16th beat-less cycle.
    set_rd(1, 25'h000700, 10'd4);
    wait_gnt(20, got_rd);
    drop_reqs();
    rd_beat = 1'b1;
    tick(3);
    rd_beat = 1'b0;
    n = 1;
    while (!abort[0] && n < 24) begin
      tick();
      n++;
    end
    check("wdog_abort_cycle", n, 16);
    check("wdog_abort_prio_inst", abort[1], 1);
    tick();
    check("wdog_err_set", err[0], 1);
    check("wdog_model_err", m[0].err, 1);
    check("wdog_to_done", busy[0], 1);
    tick();
    set_rd(1, 25'h000780, 10'd2);
    wait_gnt(20, got_rd);
    drop_reqs();
    rd_beat = 1'b1;
    wait_idle(30);
    rd_beat = 1'b0;
    check("err_sticky", err[0], 1);

    // Reset at beat 3 of 8; afterwards a tie goes to the read again.
    set_rd(1, 25'h000800, 10'd8);
    wait_gnt(20, got_rd);
    drop_reqs();
    rd_beat = 1'b1;
    tick(3);
    rst0 = 1'b1;
    #1;
    check("midrst_busy", busy[0], 0);
    check("midrst_err", err[0], 0);
    check("midrst_addr", e_addr[0], 0);
    check("midrst_len", e_len[0], 0);
    check("midrst_is_read", is_rd[0], 0);
    check("midrst_abort", abort[0], 0);
    tick(2);
    rst0 = 1'b0; rd_beat = 1'b0;
    set_rd(1, 25'h000900, 10'd3); set_wr(1, 25'h000A00, 10'd3);
    wait_gnt(20, got_rd);
    check("post_reset_read_wins", got_rd, 1);
    check("post_reset_read_wins_prio", rd_gnt[1], 1);
    drop_reqs();
    rd_beat = 1'b1;
    wait_idle(30);
    rd_beat = 1'b0;

    // Maximum length with opposite-direction noise.
    set_rd(1, 25'h1FFFFFF, 10'h3FF);
    wait_gnt(20, got_rd);
    check("maxlen_eng_len", e_len[0], 1023);
    drop_reqs();
    n = 0;
    while ((busy[0] || busy[1]) && n < 1200) begin
      rd_beat = 1'b1;
      wr_beat = 1'($urandom);
      tick();
      n++;
    end
    check("maxlen_cycles", n, 1025);
    rd_beat = 1'b0; wr_beat = 1'b0;

    // Randomised traffic.
    thr = 8;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) thr = $urandom_range(15, 1);
      for (int k = 0; k < 2; k++) begin
        if (rd_req[k] && rd_gnt[k]) rd_req[k] = 1'b0;
        else if (rd_req[k] && $urandom_range(63) == 0) rd_req[k] = 1'b0;
        else if (!rd_req[k] && $urandom_range(7) == 0) begin
          rd_req[k] = 1'b1; rd_addr[k] = AW'($urandom); rd_len[k] = LW'($urandom_range(6));
        end
        if (wr_req[k] && wr_gnt[k]) wr_req[k] = 1'b0;
        else if (wr_req[k] && $urandom_range(63) == 0) wr_req[k] = 1'b0;
        else if (!wr_req[k] && $urandom_range(7) == 0) begin
          wr_req[k] = 1'b1; wr_addr[k] = AW'($urandom); wr_len[k] = LW'($urandom_range(6));
        end
      end
      rd_beat = ($urandom_range(15) < thr);
      wr_beat = ($urandom_range(15) < thr);
      if ($urandom_range(127) == 0) init_done = ~init_done;
      ar_done = 1'b0;
      if (!aref && $urandom_range(199) == 0) aref = 1'b1;
      else if (aref && $urandom_range(15) == 0) begin
        aref = 1'b0; ar_done = 1'b1;
      end
      rst0 = ($urandom_range(1023) == 0);
      tick();
    end
    drop_reqs();
    rst0 = 1'b0; aref = 1'b0; ar_done = 1'b0; rd_beat = 1'b0; wr_beat = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr2_port_arb.md
Name: ddr2_port_arb

Overview:
- Arbitrates the shared DDR2 MIG user port between two requesters: the frame-buffer read client and the write client (fractal engine / PI write path).
- Serialises transfers and holds off new grants while an auto-refresh is pending or MIG init is incomplete.
- Issues one start pulse per granted transfer to the ddr2_mgr command engine.
- Counts completion beats and aborts transfers that stall.

Parameters:
- RD_PRIORITY, 0, 1 = read always wins contention; 0 = round-robin.
- WDOG_CYCLES, 4096, maximum consecutive XFER cycles without a beat before abort (≥2).
- ADDR_W, 25, transfer start address width (32-bit word address).
- LEN_W, 10, transfer length width in 32-bit beats.

Ports:
- clk0  in  1  memory user clock (MIG clk0 domain)
- rst0  in  1  asynchronous, active-high reset
- mig_init_done  in  1  MIG calibration complete, level
- mig_auto_ref_req  in  1  MIG refresh request, level
- mig_ar_done  in  1  MIG refresh complete, 1-cycle pulse
- rd_mem_req  in  1  read request, held until grant
- rd_mem_addr  in  ADDR_W  read start address
- rd_xfr_len  in  LEN_W  read length in beats
- rd_beat  in  1  one read beat delivered (mig_user_data_valid)
- rd_mem_grant  out  1  1-cycle read grant pulse
- wr_mem_req  in  1  write request, held until grant
- wr_mem_addr  in  ADDR_W  write start address
- wr_xfr_len  in  LEN_W  write length in beats
- wr_beat  in  1  one write beat accepted by MIG
- wr_mem_grant  out  1  1-cycle write grant pulse
- eng_start  out  1  1-cycle start pulse to command engine
- eng_is_read  out  1  direction of current transfer
- eng_addr  out  ADDR_W  latched start address
- eng_len  out  LEN_W  latched length
- eng_abort  out  1  1-cycle watchdog abort pulse
- arb_busy  out  1  state ≠ IDLE
- err_timeout  out  1  sticky watchdog flag, cleared only by rst0

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_served = WRITE, so a read wins the first contention.
  - ref_pending = 0; beat and watchdog counters 0.
- States: IDLE, GRANT, XFER, DONE, REFRESH.
- IDLE:
  - No action while mig_init_done = 0.
  - Else if mig_auto_ref_req or ref_pending → REFRESH.
  - Else if any request → GRANT.
  - Winner when both requests are active:
    - RD_PRIORITY = 1: read wins.
    - Otherwise: the side not equal to last_served wins.
  - A single requester always wins.
- GRANT, exactly 1 cycle:
  - Assert the winner's grant and eng_start together.
  - eng_is_read, eng_addr and eng_len are registered on IDLE→GRANT and held stable until the next grant.
  - Update last_served; load the beat counter with the length.
  - Length 0 → DONE with eng_start suppressed; the grant still pulses.
  - Length ≠ 0 → XFER.
  - Grant-to-request latency: request seen in cycle N gives grant in cycle N+1.
- XFER:
  - Count only the beat of the active direction; opposite-direction beats are ignored.
  - Beat counter decrements by 1 per counted beat.
  - On the beat that takes the count 1→0 → DONE.
  - Watchdog:
    - Increments every XFER cycle without a counted beat; clears on each counted beat.
    - Reaching WDOG_CYCLES pulses eng_abort, sets err_timeout, and goes → DONE.
  - mig_auto_ref_req seen during XFER sets ref_pending. The transfer is not interrupted.
- DONE, 1 cycle, then → IDLE. Requests are re-evaluated in IDLE, so there are at least 2 idle cycles between grants.
- REFRESH:
  - Clear ref_pending on entry.
  - Wait for mig_ar_done → IDLE.
  - Requests and beats are ignored; no grants are issued.
- Boundaries:
  - Beats arriving in IDLE, GRANT, DONE or REFRESH are ignored.
  - Extra beats after the count reaches 0 are ignored.
  - A refresh request and a client request in the same IDLE cycle: refresh wins.
  - Deasserting mig_init_done mid-transfer does not abort it; it only blocks new grants.
  - rst0 asserted mid-transfer immediately returns to IDLE with all outputs 0. No abort pulse is generated.
  - A requester that drops req before grant simply loses arbitration; no grant is issued.
  - Length LEN_W all-ones = 1023 beats; the counter is LEN_W bits, with no wrap because the count stops at 0.

Test Plan:
- Init gating: rd_mem_req=1, addr=0x000100, len=8 with mig_init_done=0 for 50 cycles → no grant. Raise init_done → rd_mem_grant and eng_start one cycle later, eng_is_read=1, eng_addr=0x000100, eng_len=8. After 8 rd_beat → DONE, then IDLE with arb_busy=0.
- Contention, RD_PRIORITY=0: both requesting continuously, len=4 each → grants alternate R,W,R,W starting with R. RD_PRIORITY=1 → R,R,R while rd_mem_req stays high.
- Refresh: mig_auto_ref_req asserted mid-XFER of a 16-beat write → all 16 beats complete, then REFRESH. No grant until mig_ar_done. A pending read is granted 1 cycle after returning to IDLE.
- Zero length: wr_mem_req with len=0 → wr_mem_grant pulses, eng_start stays 0, back to IDLE in 2 cycles.
- Watchdog: WDOG_CYCLES=16, read len=4 with only 2 beats delivered → eng_abort 16 cycles after the last beat. err_timeout=1 and stays 1 through later successful transfers until rst0.
- Reset mid-op: assert rst0 at beat 3 of 8 → all outputs 0 at once. After release the next read is granted normally and last_served is back at WRITE.
